// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game clock and score display.
package game_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } gclk_state_t;

    localparam int CNT_W   = 10;
    localparam int BCD_W   = 12;
    localparam int MAX_SEC = 999;

    // Clamp an 11-bit intermediate seconds value to the 3-digit display range.
    function automatic logic [CNT_W-1:0] satToMax(input logic [CNT_W:0] value);
        logic [CNT_W:0] maxExt;
        maxExt = (CNT_W+1)'(MAX_SEC);
        if (value > maxExt) begin
            return maxExt[CNT_W-1:0];
        end else begin
            return value[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bin_to_bcd3.sv
// Combinational 10-bit binary to 3-digit BCD (double-dabble); shared with the score display.
module bin_to_bcd3
    import game_timer_pkg::*;
(
    input  logic [CNT_W-1:0] bin,
    output logic [BCD_W-1:0] bcd
);

    // Shift-and-add-3 over all input bits, MSB first.
    always_comb begin
        logic [BCD_W-1:0] acc;
        acc = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 3; d++) begin
                if (acc[4*d +: 4] > 4'd4) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end else begin
                    acc[4*d +: 4] = acc[4*d +: 4];
                end
            end
            acc = {acc[BCD_W-2:0], bin[i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// Game-clock controller: one-second prescaler, idle/run/pause/expired sequencing,
// round-robin time-bonus arbitration and saturating remaining-seconds count.
module game_clock_ctrl
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ    = 31_500_000,
    parameter int START_SEC = 90,
    parameter int BONUS_SEC = 30,
    parameter int NUM_REQ   = 3,
    parameter int WARN_SEC  = 10
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startN,
    input  logic               pause,
    input  logic [NUM_REQ-1:0] add_req,
    output logic [NUM_REQ-1:0] add_ack,
    output logic [BCD_W-1:0]   sec_bcd,
    output logic               running,
    output logic               one_sec,
    output logic               time_up,
    output logic               low_time
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_SEC);
    localparam logic [CNT_W:0]   BONUS_EXT = (CNT_W+1)'(BONUS_SEC);

    gclk_state_t      state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext, cntUpd;
    logic [PW-1:0]    presc, prescNext;
    logic [RW-1:0]    rr, rrNext, rrAdv;
    logic             timeUpReg, timeUpNext;
    logic             tick, grantValid, active;
    logic [CNT_W:0]   sum;

    assign active = (state == S_RUN) || (state == S_PAUSE);
    assign tick   = (state == S_RUN) && (presc == PRESC_MAX);

    // Round-robin grant: first asserted request at or after rr, with wrap.
    always_comb begin
        int idx;
        int nxt;
        add_ack    = '0;
        grantValid = 1'b0;
        rrAdv      = rr;
        idx        = 0;
        nxt        = 0;
        if (active) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(rr) + i) % NUM_REQ;
                if (!grantValid && add_req[idx]) begin
                    grantValid   = 1'b1;
                    add_ack[idx] = 1'b1;
                    nxt          = (idx + 1) % NUM_REQ;
                    rrAdv        = RW'(nxt);
                end else begin
                    grantValid = grantValid;
                end
            end
        end else begin
            grantValid = 1'b0;
        end
    end

    // Count update: 11 bits so a bonus near the top cannot wrap before clamping.
    always_comb begin
        sum    = {1'b0, cnt} - {{CNT_W{1'b0}}, tick} + (grantValid ? BONUS_EXT : (CNT_W+1)'(0));
        cntUpd = satToMax(sum);
    end

    // Phase sequencing; expiry takes priority over a simultaneous pause request.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        prescNext  = presc;
        rrNext     = rr;
        timeUpNext = 1'b0;
        case (state)
            S_IDLE, S_EXPIRED: begin
                if (!startN) begin
                    stateNext = S_RUN;
                    cntNext   = START_CNT;
                    prescNext = '0;
                end else begin
                    stateNext = state;
                end
            end
            S_RUN: begin
                cntNext   = cntUpd;
                rrNext    = rrAdv;
                prescNext = tick ? '0 : presc + PW'(1);
                if (sum == '0) begin
                    stateNext  = S_EXPIRED;
                    timeUpNext = 1'b1;
                end else if (pause) begin
                    stateNext = S_PAUSE;
                end else begin
                    stateNext = S_RUN;
                end
            end
            S_PAUSE: begin
                cntNext = cntUpd;
                rrNext  = rrAdv;
                if (!pause) begin
                    stateNext = S_RUN;
                end else begin
                    stateNext = S_PAUSE;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            cnt       <= START_CNT;
            presc     <= '0;
            rr        <= '0;
            timeUpReg <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            presc     <= prescNext;
            rr        <= rrNext;
            timeUpReg <= timeUpNext;
        end
    end

    bin_to_bcd3 u_bcd (
        .bin (cnt),
        .bcd (sec_bcd)
    );

    assign running  = (state == S_RUN);
    assign one_sec  = tick;
    assign time_up  = timeUpReg;
    assign low_time = active && (cnt != '0) && (int'(cnt) < WARN_SEC);

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Self-checking bench for game_clock_ctrl: vector tables plus multi-cycle sequences, scoreboard-compared.
module tb_game_clock_ctrl;

    typedef struct packed {
        logic [2:0]  ack;
        logic [11:0] bcd;
        logic        run;
        logic        sec;
        logic        tup;
        logic        low;
    } obs_t;

    typedef struct {
        logic       sN;
        logic       p;
        logic [2:0] req;
        obs_t       exp;
        string      name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN1, rstN2, startN, pause;
    logic [2:0]  add_req;
    logic [2:0]  ack1, ack2;
    logic [11:0] bcd1, bcd2;
    logic        run1, run2, sec1, sec2, tup1, tup2, low1, low2;

    int   total = 0;
    int   bad   = 0;
    bit   sel   = 1'b0;
    obs_t  sbExp[$];
    string sbName[$];
    vec_t  tblA[$];
    vec_t  tblB[$];

    always #5 clk = ~clk;

    game_clock_ctrl #(.CLK_HZ(4), .START_SEC(5), .BONUS_SEC(3), .NUM_REQ(3), .WARN_SEC(3)) dut (
        .clk(clk), .resetN(rstN1), .startN(startN), .pause(pause), .add_req(add_req),
        .add_ack(ack1), .sec_bcd(bcd1), .running(run1), .one_sec(sec1), .time_up(tup1), .low_time(low1)
    );

    game_clock_ctrl #(.CLK_HZ(4), .START_SEC(998), .BONUS_SEC(30), .NUM_REQ(3), .WARN_SEC(3)) dut2 (
        .clk(clk), .resetN(rstN2), .startN(startN), .pause(pause), .add_req(add_req),
        .add_ack(ack2), .sec_bcd(bcd2), .running(run2), .one_sec(sec2), .time_up(tup2), .low_time(low2)
    );

    function automatic obs_t mk(input logic [2:0] a, input logic [11:0] b,
                                input logic r, input logic s, input logic t, input logic l);
        return {a, b, r, s, t, l};
    endfunction

    function automatic vec_t vec(input logic sN, input logic p, input logic [2:0] req,
                                 input obs_t e, input string n);
        vec_t v;
        v.sN = sN; v.p = p; v.req = req; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic obs_t observe();
        if (sel) return {ack2, bcd2, run2, sec2, tup2, low2};
        else     return {ack1, bcd1, run1, sec1, tup1, low1};
    endfunction

    task automatic checkNow();
        obs_t  e;
        obs_t  a;
        string n;
        e = sbExp.pop_front();
        n = sbName.pop_front();
        a = observe();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got ack=%b bcd=%h run=%b sec=%b tup=%b low=%b, want ack=%b bcd=%h run=%b sec=%b tup=%b low=%b",
                     n, a.ack, a.bcd, a.run, a.sec, a.tup, a.low, e.ack, e.bcd, e.run, e.sec, e.tup, e.low);
        end
    endtask

    task automatic cyc(input logic sN, input logic p, input logic [2:0] req, input obs_t e, input string n);
        startN  = sN;
        pause   = p;
        add_req = req;
        sbExp.push_back(e);
        sbName.push_back(n);
        @(negedge clk);
        checkNow();
        @(posedge clk);
        #1;
    endtask

    // Plain countdown from a fresh start of 5 s at 4 cycles per second; startN pulse at n=6 must be ignored.
    task automatic runDown(input int nLast);
        for (int n = 0; n <= nLast; n++) begin
            int c;
            c = 5 - n / 4;
            cyc((n == 6) ? 1'b0 : 1'b1, 1'b0, 3'b000,
                mk(3'b000, 12'(c), 1'b1, (n % 4 == 3), 1'b0, (c < 3)), $sformatf("down%0d", n));
        end
    endtask

    initial begin
        bit found;
        tblA.push_back(vec(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0), "idle"));
        tblA.push_back(vec(1'b1, 1'b1, 3'b111, mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0), "idle_ignore"));
        tblA.push_back(vec(1'b0, 1'b0, 3'b000, mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0), "start"));

        tblB.push_back(vec(1'b1, 1'b0, 3'b111, mk(3'b001, 12'h005, 1'b1, 1'b0, 1'b0, 1'b0), "rr0"));
        tblB.push_back(vec(1'b1, 1'b0, 3'b110, mk(3'b010, 12'h008, 1'b1, 1'b0, 1'b0, 1'b0), "rr1"));
        tblB.push_back(vec(1'b1, 1'b0, 3'b100, mk(3'b100, 12'h011, 1'b1, 1'b0, 1'b0, 1'b0), "rr2"));
        tblB.push_back(vec(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h014, 1'b1, 1'b1, 1'b0, 1'b0), "tick14"));
        tblB.push_back(vec(1'b1, 1'b0, 3'b101, mk(3'b001, 12'h013, 1'b1, 1'b0, 1'b0, 1'b0), "rr_wrap"));
        tblB.push_back(vec(1'b1, 1'b0, 3'b100, mk(3'b100, 12'h016, 1'b1, 1'b0, 1'b0, 1'b0), "rr_skip"));
        tblB.push_back(vec(1'b1, 1'b1, 3'b000, mk(3'b000, 12'h019, 1'b1, 1'b0, 1'b0, 1'b0), "pause_req"));

        rstN1 = 1'b0; rstN2 = 1'b0; startN = 1'b1; pause = 1'b0; add_req = 3'b000;
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0), "in_reset");
        rstN1 = 1'b1;

        for (int i = 0; i < tblA.size(); i++)
            cyc(tblA[i].sN, tblA[i].p, tblA[i].req, tblA[i].exp, tblA[i].name);
        runDown(19);
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0), "expire");
        cyc(1'b1, 1'b0, 3'b111, mk(3'b000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0), "expired_ignore");
        cyc(1'b0, 1'b0, 3'b000, mk(3'b000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0), "restart");

        for (int i = 0; i < tblB.size(); i++)
            cyc(tblB[i].sN, tblB[i].p, tblB[i].req, tblB[i].exp, tblB[i].name);
        // Paused with the prescaler at 3; a request mid-pause is still granted.
        for (int p = 0; p < 10; p++)
            cyc(1'b1, 1'b1, (p == 3) ? 3'b010 : 3'b000,
                mk((p == 3) ? 3'b010 : 3'b000, (p <= 3) ? 12'h019 : 12'h022, 1'b0, 1'b0, 1'b0, 1'b0),
                $sformatf("pause%0d", p));
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h022, 1'b0, 1'b0, 1'b0, 1'b0), "unpause");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h022, 1'b1, 1'b1, 1'b0, 1'b0), "resume_tick");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h021, 1'b1, 1'b0, 1'b0, 1'b0), "after_tick");

        startN = 1'b1; pause = 1'b0; add_req = 3'b010;
        #1;
        sbExp.push_back(mk(3'b010, 12'h021, 1'b1, 1'b0, 1'b0, 1'b0)); sbName.push_back("pre_reset");
        checkNow();
        rstN1 = 1'b0;
        #1;
        sbExp.push_back(mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0)); sbName.push_back("async_reset");
        checkNow();
        @(posedge clk); #1;
        rstN1 = 1'b1; add_req = 3'b000;

        cyc(1'b0, 1'b0, 3'b000, mk(3'b000, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0), "restart2");
        runDown(18);
        cyc(1'b1, 1'b0, 3'b001, mk(3'b001, 12'h001, 1'b1, 1'b1, 1'b0, 1'b1), "tick_grant");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h003, 1'b1, 1'b0, 1'b0, 1'b0), "no_expire");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h003, 1'b1, 1'b0, 1'b0, 1'b0), "still_run");

        sel = 1'b1;
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h998, 1'b0, 1'b0, 1'b0, 1'b0), "sat_in_reset");
        rstN2 = 1'b1;
        cyc(1'b0, 1'b0, 3'b000, mk(3'b000, 12'h998, 1'b0, 1'b0, 1'b0, 1'b0), "sat_start");
        cyc(1'b1, 1'b0, 3'b001, mk(3'b001, 12'h998, 1'b1, 1'b0, 1'b0, 1'b0), "sat_grant");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h999, 1'b1, 1'b0, 1'b0, 1'b0), "sat_999");

        startN = 1'b1; add_req = 3'b000; found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tup2) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL sat_expire: got no time_up within 5000 cycles, want one pulse");
        end
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 3'b000, mk(3'b000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0), "sat_restart");
        cyc(1'b1, 1'b0, 3'b000, mk(3'b000, 12'h998, 1'b1, 1'b0, 1'b0, 1'b0), "sat_reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
